// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with round-robin fairness, locked
// read-modify-write sequences and single-cycle read response routing.
// Grants are combinational from the request inputs and registered
// arbiter state; the RAM returns read data one cycle after ram_read.
module mem_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_write,
    input  logic                 m0_lock,
    input  logic [AddrWidth-1:0] m0_addr,
    input  logic [DataWidth-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [DataWidth-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_write,
    input  logic                 m1_lock,
    input  logic [AddrWidth-1:0] m1_addr,
    input  logic [DataWidth-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [DataWidth-1:0] m1_rdata,
    output logic                 ram_read,
    output logic                 ram_write,
    output logic [AddrWidth-1:0] ram_addr,
    output logic [DataWidth-1:0] ram_wdata,
    input  logic [DataWidth-1:0] ram_rdata
);

    // Arbiter state: last granted id, lock owner, outstanding read response.
    logic last_id_q, last_id_d;
    logic locked_q, locked_d;
    logic lock_id_q, lock_id_d;
    logic resp_pending_q, resp_pending_d;
    logic resp_id_q, resp_id_d;

    logic gnt0_s, gnt1_s, gnt_any_s;
    logic gnt_write_s, gnt_lock_s, lock_req_s;

    // Grant selection: lock owner has exclusive access, otherwise round-robin.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (locked_q) begin
            if (lock_id_q == 1'b0) begin
                gnt0_s = m0_req;
            end else begin
                gnt1_s = m1_req;
            end
        end else if (m0_req && m1_req) begin
            // Contended: favour the requester that was not granted last.
            if (last_id_q == 1'b1) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else begin
            gnt0_s = m0_req;
            gnt1_s = m1_req;
        end
    end

    // Mux the granted requester onto the RAM port; zeros when idle.
    always_comb begin
        gnt_any_s   = gnt0_s | gnt1_s;
        gnt_write_s = 1'b0;
        gnt_lock_s  = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        if (gnt0_s) begin
            gnt_write_s = m0_write;
            gnt_lock_s  = m0_lock;
            ram_addr    = m0_addr;
            ram_wdata   = m0_wdata;
        end else if (gnt1_s) begin
            gnt_write_s = m1_write;
            gnt_lock_s  = m1_lock;
            ram_addr    = m1_addr;
            ram_wdata   = m1_wdata;
        end else begin
            gnt_write_s = 1'b0;
            gnt_lock_s  = 1'b0;
        end
        ram_read  = gnt_any_s & ~gnt_write_s;
        ram_write = gnt_any_s & gnt_write_s;
        m0_gnt    = gnt0_s;
        m1_gnt    = gnt1_s;
    end

    // Next-state for round-robin pointer, lock tracking and read response.
    always_comb begin
        last_id_d      = last_id_q;
        locked_d       = locked_q;
        lock_id_d      = lock_id_q;
        resp_pending_d = gnt_any_s & ~gnt_write_s;
        resp_id_d      = resp_id_q;
        lock_req_s     = (lock_id_q == 1'b1) ? m1_req : m0_req;
        if (gnt_any_s) begin
            last_id_d = gnt1_s;
            resp_id_d = gnt1_s;
        end else begin
            last_id_d = last_id_q;
            resp_id_d = resp_id_q;
        end
        if (locked_q) begin
            // Owner dropping req, or an unlocked grant to the owner, ends the lock.
            if (!lock_req_s) begin
                locked_d = 1'b0;
            end else if (gnt_any_s && !gnt_lock_s) begin
                locked_d = 1'b0;
            end else begin
                locked_d = 1'b1;
            end
        end else if (gnt_any_s && gnt_lock_s) begin
            locked_d  = 1'b1;
            lock_id_d = gnt1_s;
        end else begin
            locked_d = 1'b0;
        end
    end

    // State registers; reset points round-robin at m1 so m0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_id_q      <= 1'b1;
            locked_q       <= 1'b0;
            lock_id_q      <= 1'b0;
            resp_pending_q <= 1'b0;
            resp_id_q      <= 1'b0;
        end else begin
            last_id_q      <= last_id_d;
            locked_q       <= locked_d;
            lock_id_q      <= lock_id_d;
            resp_pending_q <= resp_pending_d;
            resp_id_q      <= resp_id_d;
        end
    end

    // Route RAM read data to the requester that issued the read.
    always_comb begin
        m0_rvalid = ~reset & resp_pending_q & (resp_id_q == 1'b0);
        m1_rvalid = ~reset & resp_pending_q & (resp_id_q == 1'b1);
        if (m0_rvalid) begin
            m0_rdata = ram_rdata;
        end else begin
            m0_rdata = '0;
        end
        if (m1_rvalid) begin
            m1_rdata = ram_rdata;
        end else begin
            m1_rdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a vector table walks through
// contended reads, writes, locked sequences and strict alternation,
// followed by hand-written reset/lock corner-case sequences.
module tb_mem_arbiter;

    typedef struct {
        logic        req;
        logic        wr;
        logic        lk;
        logic [31:0] addr;
        logic [31:0] wd;
    } mreq_t;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        v0;
        logic        v1;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] d0;
        logic [31:0] d1;
    } out_t;

    typedef struct {
        logic  rst;
        mreq_t m0;
        mreq_t m1;
        out_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_write = 1'b0, m0_lock = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic        m1_req = 1'b0, m1_write = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_read, ram_write;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    mem_arbiter #(.AddrWidth(32), .DataWidth(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Simple RAM: write on strobe, read data one cycle after ram_read.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= ram_read ? mem[ram_addr[7:0]] : 32'h0;
    end

    function automatic mreq_t idle();
        mreq_t r = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        return r;
    endfunction

    function automatic mreq_t rd(input logic [31:0] a, input logic lk);
        mreq_t r = '{1'b1, 1'b0, lk, a, 32'h0};
        return r;
    endfunction

    function automatic mreq_t wr(input logic [31:0] a, input logic [31:0] d, input logic lk);
        mreq_t r = '{1'b1, 1'b1, lk, a, d};
        return r;
    endfunction

    function automatic out_t ex(input logic g0, input logic g1, input logic v0, input logic v1,
                                input logic rdd, input logic wrr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] d0, input logic [31:0] d1);
        out_t o;
        o.g0 = g0; o.g1 = g1; o.v0 = v0; o.v1 = v1; o.rd = rdd; o.wr = wrr;
        o.addr = a; o.wd = wd; o.d0 = d0; o.d1 = d1;
        return o;
    endfunction

    function automatic out_t none();
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endfunction

    function automatic vec_t mk(input logic rst, input mreq_t a, input mreq_t b, input out_t e);
        vec_t v;
        v.rst = rst; v.m0 = a; v.m1 = b; v.exp = e;
        return v;
    endfunction

    // Drive one cycle of inputs after the falling edge, then compare outputs.
    task automatic apply(input vec_t v, input string nm);
        out_t act;
        @(negedge clk);
        reset = v.rst;
        m0_req = v.m0.req; m0_write = v.m0.wr; m0_lock = v.m0.lk;
        m0_addr = v.m0.addr; m0_wdata = v.m0.wd;
        m1_req = v.m1.req; m1_write = v.m1.wr; m1_lock = v.m1.lk;
        m1_addr = v.m1.addr; m1_wdata = v.m1.wd;
        #1;
        act = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_read, ram_write,
               ram_addr, ram_wdata, m0_rdata, m1_rdata};
        checks++;
        if (act !== v.exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, v.exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;

        // Reset gating, contended reads, single write, lock hold, lock drop.
        tbl.push_back(mk(1'b1, rd(32'h10, 1'b0), idle(), none()));
        tbl.push_back(mk(1'b1, rd(32'h10, 1'b0), rd(32'h20, 1'b0), none()));
        tbl.push_back(mk(1'b0, rd(32'h10, 1'b0), rd(32'h20, 1'b0),
                         ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), rd(32'h20, 1'b0),
                         ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hA000_0010, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), idle(),
                         ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA000_0020)));
        tbl.push_back(mk(1'b0, idle(), wr(32'h08, 32'hDEAD_BEEF, 1'b0),
                         ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), idle(), none()));
        tbl.push_back(mk(1'b0, rd(32'h08, 1'b0), idle(),
                         ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), idle(),
                         ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), rd(32'h30, 1'b0),
                         ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk(1'b0, rd(32'h04, 1'b1), rd(32'h30, 1'b0),
                         ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04, 32'h0, 32'h0, 32'hA000_0030)));
        tbl.push_back(mk(1'b0, wr(32'h04, 32'h1234_5678, 1'b0), rd(32'h30, 1'b0),
                         ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 32'h1234_5678, 32'hA000_0004, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), rd(32'h30, 1'b0),
                         ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk(1'b0, rd(32'h40, 1'b1), rd(32'h50, 1'b0),
                         ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'hA000_0030)));
        tbl.push_back(mk(1'b0, idle(), rd(32'h50, 1'b0),
                         ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA000_0040, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), rd(32'h50, 1'b0),
                         ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk(1'b0, idle(), idle(),
                         ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA000_0050)));
        // Eight cycles of continuous contention: strict m0/m1 alternation.
        for (int i = 0; i < 8; i++) begin
            logic g0, v0, v1;
            g0 = (i % 2 == 0);
            v0 = (i > 0) && (i % 2 == 1);
            v1 = (i > 0) && (i % 2 == 0);
            tbl.push_back(mk(1'b0, rd(32'h60, 1'b0), rd(32'h70, 1'b0),
                             ex(g0, ~g0, v0, v1, 1'b1, 1'b0, g0 ? 32'h60 : 32'h70, 32'h0,
                                v0 ? 32'hA000_0060 : 32'h0, v1 ? 32'hA000_0070 : 32'h0)));
        end
        tbl.push_back(mk(1'b0, idle(), idle(),
                         ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA000_0070)));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset right after a granted read: response dropped, m0 wins next contention.
        apply(mk(1'b0, rd(32'h10, 1'b0), rd(32'h20, 1'b0),
                 ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0)), "rst_rd_grant");
        apply(mk(1'b1, idle(), rd(32'h20, 1'b0), none()), "rst_rd_inreset");
        apply(mk(1'b0, rd(32'h30, 1'b0), rd(32'h20, 1'b0),
                 ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0)), "rst_rd_after");
        apply(mk(1'b0, idle(), idle(),
                 ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA000_0030, 32'h0)), "rst_rd_resp");

        // Reset while m0 holds a lock: lock must not block m1 afterwards.
        apply(mk(1'b0, rd(32'h10, 1'b1), idle(),
                 ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0)), "rst_lk_grant");
        apply(mk(1'b1, idle(), idle(), none()), "rst_lk_inreset");
        apply(mk(1'b0, idle(), rd(32'h20, 1'b0),
                 ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0)), "rst_lk_m1");
        apply(mk(1'b0, idle(), idle(),
                 ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA000_0020)), "rst_lk_resp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
